// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the response FIFO payload. ALU_SEQ_TAG_EN adds a 4-bit tag to the payload.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned TAG_W  = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_SHL = 3'b010;
    localparam logic [OP_W-1:0] ALU_SHR = 3'b011;
    localparam logic [OP_W-1:0] ALU_AND = 3'b100;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b101;
    localparam logic [OP_W-1:0] ALU_XOR = 3'b110;
    localparam logic [OP_W-1:0] ALU_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } seq_state_t;

    typedef struct packed {
`ifdef ALU_SEQ_TAG_EN
        logic [TAG_W-1:0]  tag;
`endif
        logic [DATA_W-1:0] data;
        logic              zero;
    } rsp_entry_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Small synchronous FIFO holding captured ALU results. DEPTH must be a power
// of two so the pointers wrap naturally. Pop on empty is ignored; push on
// full is only accepted together with a pop.
module alu_rsp_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualified push/pop and head/empty views
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
        empty   = (count == '0);
        rd_data = mem[rd_ptr];
    end

    // Storage array, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 8-bit ALU operand interface: accepts a command, holds the
// operands on alu_* for SETTLE_CYCLES, captures alu_out into a response FIFO
// and returns results in order. ALU_SEQ_TAG_EN adds cmd_tag/rsp_tag.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
`ifdef ALU_SEQ_TAG_EN
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [TAG_W-1:0]  rsp_tag,
`endif
    output logic              busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_t     state;
    seq_state_t     state_nxt;
    logic [SW-1:0]  settle_cnt;
    logic           accept;
    logic           push;
    logic           pop;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic           empty;
    rsp_entry_t     wr_entry;
    rsp_entry_t     rd_entry;
`ifdef ALU_SEQ_TAG_EN
    logic [TAG_W-1:0] tag_q;
`endif

    // Handshakes, predicted occupancy and next state
    always_comb begin
        accept    = (state == IDLE) && cmd_valid && cmd_ready;
        push      = (state == CAPTURE);
        pop       = !empty && rsp_ready;
        count_nxt = count + CW'(push) - CW'(pop);
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (settle_cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, settle counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
`ifdef ALU_SEQ_TAG_EN
            tag_q      <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE) && (count_nxt < CW'(DEPTH));
            busy      <= (state_nxt != IDLE);
            if (accept) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_op     <= cmd_op;
                settle_cnt <= SW'(SETTLE_CYCLES - 1);
`ifdef ALU_SEQ_TAG_EN
                tag_q      <= cmd_tag;
`endif
            end else if ((state == ISSUE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SW'(1);
            end
        end
    end

    // Captured entry and head-of-FIFO response view
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = alu_out;
        wr_entry.zero = (alu_out == '0);
`ifdef ALU_SEQ_TAG_EN
        wr_entry.tag  = tag_q;
        rsp_tag       = empty ? '0 : rd_entry.tag;
`endif
        rsp_valid     = !empty;
        rsp_data      = empty ? '0 : rd_entry.data;
        rsp_zero      = empty ? 1'b1 : rd_entry.zero;
    end

    alu_rsp_fifo #(
        .WIDTH ($bits(rsp_entry_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .count   (count),
        .empty   (empty)
    );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios plus randomized traffic,
// scoreboarded against a cycle-level transaction model of accepted commands.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 1;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic [3:0] cmd_tag;
    logic [3:0] rsp_tag;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit up       = 0;
    bit rand_done;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
        logic [7:0] res;
        int         vis;
    } exp_t;

    exp_t q[$];
    logic [7:0] exp_seq [4];
    logic [3:0] exp_tag [4];

    alu_cmd_sequencer #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
`ifdef ALU_SEQ_TAG_EN
        .cmd_tag   (cmd_tag),
        .rsp_tag   (rsp_tag),
`endif
        .busy      (busy)
    );

`ifndef ALU_SEQ_TAG_EN
    assign rsp_tag = 4'h0;
`endif

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SHL: return a << b[2:0];
            ALU_SHR: return a >> b[2:0];
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return (a == b) ? 8'h01 : 8'h00;
        endcase
    endfunction

    // Team ALU model on the operand interface
    assign alu_out = alu_f(alu_op, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        up  = rst_n;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: a command accepted before edge N becomes visible after edge
    // N+SETTLE+1; it is in flight until then, and nothing is accepted meanwhile.
    always @(negedge clk) begin
        int   vis_n;
        bit   infl;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            check_eq("rst_cmd_ready", cmd_ready, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_rsp_valid", rsp_valid, 0);
            check_eq("rst_rsp_data", rsp_data, 0);
            check_eq("rst_rsp_zero", rsp_zero, 1);
            check_eq("rst_alu", {alu_op, alu_a, alu_b}, 0);
            check_eq("rst_rsp_tag", rsp_tag, 0);
        end else begin
            vis_n = 0;
            foreach (q[i]) if (q[i].vis <= cyc) vis_n++;
            infl = (q.size() > 0) && (q[q.size()-1].vis > cyc);
            check_eq("cmd_ready", cmd_ready, up && !infl && (vis_n < DEPTH));
            check_eq("busy", busy, infl);
            check_eq("rsp_valid", rsp_valid, vis_n > 0);
            if (infl) begin
                e = q[q.size()-1];
                check_eq("alu_hold", {alu_op, alu_a, alu_b}, {e.op, e.a, e.b});
            end
            if (vis_n > 0) begin
                check_eq("rsp_data", rsp_data, q[0].res);
                check_eq("rsp_zero", rsp_zero, q[0].res == 8'h00);
`ifdef ALU_SEQ_TAG_EN
                check_eq("rsp_tag", rsp_tag, q[0].tag);
`endif
                if (rsp_ready) void'(q.pop_front());
            end
            if (cmd_valid && up && !infl && (vis_n < DEPTH)) begin
                e.op  = cmd_op;
                e.a   = cmd_a;
                e.b   = cmd_b;
                e.tag = cmd_tag;
                e.res = alu_f(cmd_op, cmd_a, cmd_b);
                e.vis = cyc + 1 + int'(SETTLE) + 1;
                q.push_back(e);
            end
        end
    end

    // Offer a command and wait (bounded) until it is accepted
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] tag, output int acc_cyc);
        bit ok = 0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_op    = $urandom_range(0, 7);
        cmd_a     = $urandom;
        cmd_b     = $urandom;
    endtask

    // One command into an empty FIFO with rsp_ready=1: latency, busy span, result
    task automatic run_one(input string nm, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_d, input logic exp_z);
        int acc;
        int busy_n = 0;
        int lat    = -1;
        logic [7:0] d = 8'hxx;
        logic z = 1'bx;
        send_cmd(op, a, b, 4'h0, acc);
        for (int k = 0; k < int'(SETTLE) + 3; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (rsp_valid && lat < 0) begin
                lat = cyc - acc;
                d   = rsp_data;
                z   = rsp_zero;
            end
        end
        check_eq({nm, "_data"}, d, exp_d);
        check_eq({nm, "_zero"}, z, exp_z);
        check_eq({nm, "_latency"}, lat, SETTLE + 1);
        check_eq({nm, "_busy_cycles"}, busy_n, SETTLE + 1);
        @(posedge clk);
        #1;
    endtask

    // Expect the next n pops to match exp_seq/exp_tag
    task automatic collect(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            bit ok = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (rsp_valid && rsp_ready) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) check_eq({nm, "_pop_timeout"}, 0, 1);
            check_eq({nm, "_pop_data"}, rsp_data, exp_seq[i]);
`ifdef ALU_SEQ_TAG_EN
            check_eq({nm, "_pop_tag"}, rsp_tag, exp_tag[i]);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'h0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_tag   = 4'h0;
        rsp_ready = 1'b1;
        rand_done = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_rsp_zero", rsp_zero, 1);
        check_eq("reset_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        run_one("add", ALU_ADD, 8'h0F, 8'h01, 8'h10, 1'b0);
        run_one("sub", ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1);
        run_one("eq",  ALU_EQ,  8'h33, 8'h33, 8'h01, 1'b0);

        // Back-pressure: four results fill the FIFO, the fifth command waits
        rsp_ready = 1'b0;
        send_cmd(ALU_AND, 8'hF0, 8'h3C, 4'h0, acc);
        send_cmd(ALU_AND, 8'hF0, 8'h0F, 4'h0, acc);
        send_cmd(ALU_AND, 8'hF0, 8'hFF, 4'h0, acc);
        send_cmd(ALU_AND, 8'hF0, 8'h00, 4'h0, acc);
        exp_seq = '{8'h30, 8'h00, 8'hF0, 8'h00};
        exp_tag = '{4'h0, 4'h0, 4'h0, 4'h0};
        fork
            send_cmd(ALU_AND, 8'hF0, 8'hAA, 4'h0, acc);
            begin
                repeat (4) @(negedge clk);
                check_eq("bp_full_ready", cmd_ready, 0);
                check_eq("bp_full_busy", busy, 0);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
                collect("bp", 4);
            end
        join
        exp_seq[0] = 8'hA0;
        collect("bp5", 1);

        // Three queued results plus one in flight, pop on the capture cycle
        rsp_ready = 1'b0;
        send_cmd(ALU_ADD, 8'h10, 8'h01, 4'h0, acc);
        send_cmd(ALU_ADD, 8'h20, 8'h02, 4'h0, acc);
        send_cmd(ALU_ADD, 8'h30, 8'h03, 4'h0, acc);
        send_cmd(ALU_ADD, 8'h40, 8'h04, 4'h0, acc);
        @(posedge clk);
        #1;
        check_eq("pp_capture_busy", busy, 1);
        rsp_ready = 1'b1;
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        collect("pp", 4);

        // Reset while a command is settling: it must never produce a result
        send_cmd(ALU_XOR, 8'hAA, 8'h55, 4'h0, acc);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_alu_a", alu_a, 0);
        check_eq("rst_mid_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        run_one("post_rst_add", ALU_ADD, 8'h01, 8'h01, 8'h02, 1'b0);

`ifdef ALU_SEQ_TAG_EN
        rsp_ready = 1'b0;
        send_cmd(ALU_OR, 8'h01, 8'h02, 4'h3, acc);
        send_cmd(ALU_OR, 8'h50, 8'h0C, 4'hC, acc);
        exp_seq[0] = 8'h03; exp_tag[0] = 4'h3;
        exp_seq[1] = 8'h5C; exp_tag[1] = 4'hC;
        rsp_ready = 1'b1;
        collect("tag", 2);
`endif

        // Randomized traffic with random consumer back-pressure
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                             4'($urandom), acc);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
        check_eq("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
